// File: rtl/quad_velocity.sv
// Velocity estimator: samples a signed quadrature position on a fixed grid,
// differences successive samples and smooths the result with a 2^AVG_LOG2 moving average.
module quad_velocity #(
    parameter int unsigned WIDTH         = 24,
    parameter int unsigned SAMPLE_DIV    = 32000,
    parameter int unsigned AVG_LOG2      = 2,
    parameter int unsigned STALL_SAMPLES = 8
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [WIDTH-1:0] position,
    input  logic             clear,
    output logic [WIDTH-1:0] velocity,
    output logic             velocity_valid,
    output logic             stalled,
    output logic             primed
);

    localparam int unsigned DIV_W   = $clog2(SAMPLE_DIV);
    localparam int unsigned DEPTH   = 1 << AVG_LOG2;
    localparam int unsigned PTR_W   = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int unsigned SUM_W   = WIDTH + AVG_LOG2;
    localparam int unsigned STALL_W = $clog2(STALL_SAMPLES + 1);

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACCUM   = 2'd2,
        ST_PUBLISH = 2'd3
    } state_t;

    state_t                   state;
    logic [DIV_W-1:0]         divider;
    logic                     tick;
    logic [WIDTH-1:0]         prev_pos;
    logic signed [WIDTH-1:0]  delta;
    logic signed [WIDTH-1:0]  hist [DEPTH];
    logic [PTR_W-1:0]         wr_ptr;
    logic signed [SUM_W-1:0]  sum;
    logic signed [SUM_W-1:0]  sum_nxt;
    logic [STALL_W-1:0]       stall_cnt;
    logic [STALL_W-1:0]       stall_nxt;
    logic [PTR_W-1:0]         ptr_nxt;

    assign tick = (divider == DIV_W'(SAMPLE_DIV - 1));

    // Free-running sample-rate divider; clear deliberately leaves it alone to keep the grid.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            divider <= '0;
        end else if (tick) begin
            divider <= '0;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    // Window update and stall bookkeeping for the ACCUM step.
    always_comb begin
        sum_nxt   = sum + SUM_W'(delta) - SUM_W'(hist[wr_ptr]);
        ptr_nxt   = (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        stall_nxt = '0;
        if (delta == '0) begin
            stall_nxt = (stall_cnt == STALL_W'(STALL_SAMPLES)) ? stall_cnt : stall_cnt + 1'b1;
        end
    end

    // Velocity is loaded on the ACCUM edge so it is already valid throughout PUBLISH.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state          <= ST_WAIT;
            prev_pos       <= '0;
            delta          <= '0;
            wr_ptr         <= '0;
            sum            <= '0;
            stall_cnt      <= '0;
            velocity       <= '0;
            velocity_valid <= 1'b0;
            stalled        <= 1'b0;
            primed         <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else if (clear) begin
            state          <= ST_WAIT;
            wr_ptr         <= '0;
            sum            <= '0;
            stall_cnt      <= '0;
            velocity       <= '0;
            velocity_valid <= 1'b0;
            stalled        <= 1'b0;
            primed         <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                hist[i] <= '0;
            end
        end else begin
            velocity_valid <= 1'b0;
            case (state)
                ST_WAIT: begin
                    if (tick) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    prev_pos <= position;
                    if (!primed) begin
                        primed <= 1'b1;
                        state  <= ST_WAIT;
                    end else begin
                        delta <= $signed(position - prev_pos);
                        state <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    sum            <= sum_nxt;
                    hist[wr_ptr]   <= delta;
                    wr_ptr         <= ptr_nxt;
                    stall_cnt      <= stall_nxt;
                    stalled        <= (stall_nxt == STALL_W'(STALL_SAMPLES));
                    velocity       <= WIDTH'(sum_nxt >>> AVG_LOG2);
                    velocity_valid <= 1'b1;
                    state          <= ST_PUBLISH;
                end
                ST_PUBLISH: begin
                    state <= ST_WAIT;
                end
                default: begin
                    state <= ST_WAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_quad_velocity.sv
// Directed bench for quad_velocity: one averaging instance (depth 4) and one raw-delta instance
// run in lockstep on an 8-cycle sample grid.
module tb_quad_velocity;

    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic [23:0] position;
    logic [23:0] vel_a, vel_b;
    logic        valid_a, valid_b, stalled_a, stalled_b, primed_a, primed_b;

    int checks = 0;
    int errors = 0;
    int cyc;
    int stray = 0;
    int ramp_exp [6] = '{0, 1, 2, 3, 3, 3};

    quad_velocity #(.WIDTH(24), .SAMPLE_DIV(8), .AVG_LOG2(2), .STALL_SAMPLES(3)) dut_a (
        .CLK(clk), .reset(reset), .position(position), .clear(clear),
        .velocity(vel_a), .velocity_valid(valid_a), .stalled(stalled_a), .primed(primed_a)
    );

    quad_velocity #(.WIDTH(24), .SAMPLE_DIV(8), .AVG_LOG2(0), .STALL_SAMPLES(3)) dut_b (
        .CLK(clk), .reset(reset), .position(position), .clear(clear),
        .velocity(vel_b), .velocity_valid(valid_b), .stalled(stalled_b), .primed(primed_b)
    );

    always #5 clk = ~clk;

    // Bench-side cycle count since reset release: tick at cyc%8==7, valid expected at cyc%8==2.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (!reset && (valid_a || valid_b) && (cyc % 8) != 2) stray++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic to_phase(input int ph);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((cyc % 8) != ph && n < 20);
        if ((cyc % 8) != ph) begin
            checks++;
            errors++;
            $display("FAIL phase_timeout got %0d exp %0d", cyc % 8, ph);
        end
    endtask

    task automatic sample(input string tag, input logic [23:0] pos, input logic [23:0] ea,
                          input logic [23:0] eb, input logic pre, input logic post);
        position = pos;
        to_phase(1);
        chk({tag, "_stall_pre"}, 32'(stalled_a), 32'(pre));
        to_phase(2);
        chk({tag, "_valid_a"}, 32'(valid_a), 32'd1);
        chk({tag, "_valid_b"}, 32'(valid_b), 32'd1);
        chk({tag, "_vel_a"}, 32'(vel_a), 32'(ea));
        chk({tag, "_vel_b"}, 32'(vel_b), 32'(eb));
        chk({tag, "_stalled"}, 32'(stalled_a), 32'(post));
    endtask

    initial begin
        reset    = 1'b1;
        clear    = 1'b0;
        position = 24'd1000;
        repeat (5) @(negedge clk);
        chk("rst_vel", 32'(vel_a), 32'd0);
        chk("rst_valid", 32'(valid_a), 32'd0);
        chk("rst_stalled", 32'(stalled_a), 32'd0);
        chk("rst_primed", 32'(primed_a), 32'd0);
        reset = 1'b0;

        to_phase(2);
        chk("primed_early", 32'(primed_a), 32'd0);
        to_phase(2);
        chk("primed_first", 32'(primed_a), 32'd1);
        chk("prime_no_valid", 32'(valid_a), 32'd0);

        for (int i = 0; i < 6; i++) begin
            sample("ramp", 24'(1003 + 3 * i), 24'(ramp_exp[i]), 24'd3, 1'b0, 1'b0);
        end

        sample("zero1", 24'd1018, 24'd2, 24'd0, 1'b0, 1'b0);
        sample("zero2", 24'd1018, 24'd1, 24'd0, 1'b0, 1'b0);
        sample("zero3", 24'd1018, 24'd0, 24'd0, 1'b0, 1'b1);
        sample("zero4", 24'd1018, 24'd0, 24'd0, 1'b1, 1'b1);

        sample("neg1",  24'd1017, 24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0);
        sample("negz1", 24'd1017, 24'hFFFFFF, 24'd0, 1'b0, 1'b0);
        sample("negz2", 24'd1017, 24'hFFFFFF, 24'd0, 1'b0, 1'b0);
        sample("negz3", 24'd1017, 24'hFFFFFF, 24'd0, 1'b0, 1'b1);
        sample("negz4", 24'd1017, 24'd0, 24'd0, 1'b1, 1'b1);

        position = 24'd500;
        to_phase(1);
        clear = 1'b1;
        to_phase(2);
        clear = 1'b0;
        chk("clr_valid_a", 32'(valid_a), 32'd0);
        chk("clr_valid_b", 32'(valid_b), 32'd0);
        chk("clr_vel_a", 32'(vel_a), 32'd0);
        chk("clr_vel_b", 32'(vel_b), 32'd0);
        chk("clr_primed", 32'(primed_a), 32'd0);
        chk("clr_stalled", 32'(stalled_a), 32'd0);

        position = 24'h7FFFFE;
        to_phase(2);
        chk("reprime_valid", 32'(valid_a), 32'd0);
        chk("reprime_primed", 32'(primed_a), 32'd1);

        sample("wrap1", 24'h7FFFFF, 24'd0, 24'd1, 1'b0, 1'b0);
        sample("wrap2", 24'h800000, 24'd0, 24'd1, 1'b0, 1'b0);
        sample("wrap3", 24'h800001, 24'd0, 24'd1, 1'b0, 1'b0);
        sample("rev1",  24'h800000, 24'd0, 24'hFFFFFF, 1'b0, 1'b0);
        sample("rev2",  24'h7FFFFF, 24'd0, 24'hFFFFFF, 1'b0, 1'b0);

        position = 24'h7FFFFD;
        to_phase(1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rstpub_valid_a", 32'(valid_a), 32'd0);
        chk("rstpub_valid_b", 32'(valid_b), 32'd0);
        chk("rstpub_vel_b", 32'(vel_b), 32'd0);
        chk("rstpub_primed", 32'(primed_a), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (12) @(negedge clk);
        chk("stray_valid", 32'(stray), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
